// File: rtl/inst_decode_reg.sv
// inst_decode_reg: fetch-to-decode pipeline register.
//
// Captures the fetched instruction and its PC and applies stall/flush control.
// It also pre-decodes the opcode into a registered immediate-format select for
// the decode-stage immediate generator. Unsupported opcodes are flagged, and a
// wrapping count is kept of the valid instructions that enter decode.
//
// Ports
//   clk, rst              core clock, synchronous active-high reset
//   if_inst, if_pc        fetched instruction word and its PC
//   if_valid              if_* carry a real instruction
//   stall                 hold every stage register
//   flush                 load a bubble (wins over stall)
//   id_inst, id_pc        registered instruction / PC
//   id_valid              id_inst is a real instruction
//   imm_sel               immediate format: 0 I, 1 S, 2 B, 3 U, 4 J, 5 CSR-imm
//   id_illegal            valid instruction with an unsupported opcode
//   id_rs1, id_rs2, id_rd register-index fields sliced from id_inst
//   inst_cnt              count of valid instructions loaded (wraps at 2^32)
module inst_decode_reg #(
  parameter logic [31:0] RESET_PC = 32'h4000_0000,
  parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] if_inst,
  input  logic [31:0] if_pc,
  input  logic        if_valid,
  input  logic        stall,
  input  logic        flush,
  output logic [31:0] id_inst,
  output logic [31:0] id_pc,
  output logic        id_valid,
  output logic [2:0]  imm_sel,
  output logic        id_illegal,
  output logic [4:0]  id_rs1,
  output logic [4:0]  id_rs2,
  output logic [4:0]  id_rd,
  output logic [31:0] inst_cnt
);

  localparam logic [2:0] IMM_I   = 3'd0;
  localparam logic [2:0] IMM_S   = 3'd1;
  localparam logic [2:0] IMM_B   = 3'd2;
  localparam logic [2:0] IMM_U   = 3'd3;
  localparam logic [2:0] IMM_J   = 3'd4;
  localparam logic [2:0] IMM_CSR = 3'd5;

  // Returns {illegal, imm_sel}. Formats with no immediate (OP, register CSR
  // forms) use I because the immediate generator output is ignored there.
  function automatic logic [3:0] predecode(input logic [31:0] inst);
    logic [2:0] sel;
    logic       ill;
    sel = IMM_I;
    ill = 1'b0;
    case (inst[6:0])
      7'b0010011, 7'b0000011, 7'b1100111, 7'b0110011: sel = IMM_I;
      7'b0100011: sel = IMM_S;
      7'b1100011: sel = IMM_B;
      7'b0110111, 7'b0010111: sel = IMM_U;
      7'b1101111: sel = IMM_J;
      7'b1110011: sel = inst[14] ? IMM_CSR : IMM_I;
      default: ill = 1'b1;
    endcase
    return {ill, sel};
  endfunction

  logic [3:0] dec_p0;
  logic       bubble_p0;

  assign dec_p0    = predecode(if_inst);
  // An invalid fetch on an un-stalled edge behaves exactly like a flush.
  assign bubble_p0 = flush | (~stall & ~if_valid);

  // ---- fetch -> decode boundary ----
  always_ff @(posedge clk) begin
    if (rst) begin
      id_inst    <= NOP_INST;
      id_pc      <= RESET_PC;
      id_valid   <= 1'b0;
      imm_sel    <= IMM_I;
      id_illegal <= 1'b0;
      inst_cnt   <= '0;
    end else if (bubble_p0) begin
      id_inst    <= NOP_INST;
      id_pc      <= if_pc;
      id_valid   <= 1'b0;
      imm_sel    <= IMM_I;
      id_illegal <= 1'b0;
    end else if (!stall) begin
      id_inst    <= if_inst;
      id_pc      <= if_pc;
      id_valid   <= 1'b1;
      imm_sel    <= dec_p0[2:0];
      id_illegal <= dec_p0[3];
      inst_cnt   <= inst_cnt + 32'd1;
    end
  end

  assign id_rs1 = id_inst[19:15];
  assign id_rs2 = id_inst[24:20];
  assign id_rd  = id_inst[11:7];

endmodule

// File: tb/tb_inst_decode_reg.sv
module tb_inst_decode_reg;

  logic        clk = 1'b0;
  logic        rst, if_valid, stall, flush;
  logic [31:0] if_inst, if_pc;
  logic [31:0] id_inst, id_pc, inst_cnt;
  logic        id_valid, id_illegal;
  logic [2:0]  imm_sel;
  logic [4:0]  id_rs1, id_rs2, id_rd;

  int checks = 0;
  int failures = 0;

  typedef struct packed {
    logic [31:0] inst;
    logic [31:0] pc;
    logic        valid;
    logic [2:0]  sel;
    logic        ill;
    logic [31:0] cnt;
  } exp_t;

  exp_t sb[$];
  exp_t m;   // reference model state

  always #5 clk = ~clk;

  inst_decode_reg dut (
    .clk(clk), .rst(rst), .if_inst(if_inst), .if_pc(if_pc), .if_valid(if_valid),
    .stall(stall), .flush(flush), .id_inst(id_inst), .id_pc(id_pc),
    .id_valid(id_valid), .imm_sel(imm_sel), .id_illegal(id_illegal),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd), .inst_cnt(inst_cnt)
  );

  function automatic exp_t got();
    exp_t g;
    g.inst = id_inst; g.pc = id_pc; g.valid = id_valid;
    g.sel = imm_sel; g.ill = id_illegal; g.cnt = inst_cnt;
    return g;
  endfunction

  // Reference table for the immediate format of each opcode.
  function automatic logic [3:0] ref_decode(input logic [31:0] inst);
    case (inst[6:0])
      7'h13, 7'h03, 7'h67, 7'h33: return 4'h0;
      7'h23: return 4'h1;
      7'h63: return 4'h2;
      7'h37, 7'h17: return 4'h3;
      7'h6F: return 4'h4;
      7'h73: return (inst[14]) ? 4'h5 : 4'h0;
      default: return 4'h8;
    endcase
  endfunction

  // Advance the model, push its expectation, then apply inputs for one edge.
  task automatic cyc(input logic [31:0] inst, input logic [31:0] pc,
                     input logic v, input logic st, input logic fl, input logic r);
    logic [3:0] d;
    d = ref_decode(inst);
    if (r) begin
      m = '{inst: 32'h13, pc: 32'h4000_0000, valid: 1'b0, sel: 3'd0, ill: 1'b0, cnt: 32'd0};
    end else if (fl || (!st && !v)) begin
      m.inst = 32'h13; m.pc = pc; m.valid = 1'b0; m.sel = 3'd0; m.ill = 1'b0;
    end else if (!st) begin
      m.inst = inst; m.pc = pc; m.valid = 1'b1; m.sel = d[2:0]; m.ill = d[3];
      m.cnt = m.cnt + 32'd1;
    end
    sb.push_back(m);
    if_inst = inst; if_pc = pc; if_valid = v; stall = st; flush = fl; rst = r;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    exp_t e;
    for (int i = 0; i < 2; i++) begin
      cyc(32'h0050_0093, 32'h1234_5678, 1'b1, 1'b0, 1'b0, 1'b1);
      e = sb.pop_front();
      checks++;
      if (got() !== e) begin
        failures++;
        $display("FAIL reset[%0d] got=%h expected=%h", i, got(), e);
      end
    end
  endtask

  task automatic test_format_decode();
    logic [31:0] prog [6] = '{32'h0050_0093, 32'h0011_2223, 32'hFE00_98E3,
                              32'h1234_50B7, 32'h0080_006F, 32'h3402_D073};
    exp_t e;
    for (int i = 0; i < 6; i++) begin
      cyc(prog[i], 32'h4000_0000 + 32'(4 * i), 1'b1, 1'b0, 1'b0, 1'b0);
      e = sb.pop_front();
      checks++;
      if (got() !== e || imm_sel !== 3'(i) || inst_cnt !== 32'(i + 1)) begin
        failures++;
        $display("FAIL decode[%0d] got=%h expected=%h", i, got(), e);
      end
      checks++;
      if ({id_rs1, id_rs2, id_rd} !== {prog[i][19:15], prog[i][24:20], prog[i][11:7]}) begin
        failures++;
        $display("FAIL regfields[%0d] got=%h expected=%h", i,
                 {id_rs1, id_rs2, id_rd}, {prog[i][19:15], prog[i][24:20], prog[i][11:7]});
      end
    end
    // Non-immediate encodings that still decode as format 0 and are legal
    cyc(32'h3020_0073, 32'h4000_0100, 1'b1, 1'b0, 1'b0, 1'b0);  // mret (funct3=0)
    e = sb.pop_front();
    checks++;
    if (got() !== e) begin
      failures++;
      $display("FAIL system_reg got=%h expected=%h", got(), e);
    end
    cyc(32'h0020_81B3, 32'h4000_0104, 1'b1, 1'b0, 1'b0, 1'b0);  // add
    e = sb.pop_front();
    checks++;
    if (got() !== e) begin
      failures++;
      $display("FAIL op_reg got=%h expected=%h", got(), e);
    end
  endtask

  task automatic test_stall();
    exp_t e;
    cyc(32'h0011_2223, 32'h4000_0010, 1'b1, 1'b0, 1'b0, 1'b0);
    e = sb.pop_front();
    checks++;
    if (got() !== e) begin
      failures++;
      $display("FAIL stall_load got=%h expected=%h", got(), e);
    end
    for (int i = 0; i < 3; i++) begin
      cyc(32'h1234_50B7 + 32'(i << 12), 32'h4000_0014 + 32'(i), 1'b1, 1'b1, 1'b0, 1'b0);
      e = sb.pop_front();
      checks++;
      if (got() !== e || id_inst !== 32'h0011_2223 || imm_sel !== 3'd1) begin
        failures++;
        $display("FAIL stall_hold[%0d] got=%h expected=%h", i, got(), e);
      end
    end
    cyc(32'h0050_0093, 32'h4000_0014, 1'b1, 1'b0, 1'b0, 1'b0);
    e = sb.pop_front();
    checks++;
    if (got() !== e) begin
      failures++;
      $display("FAIL stall_release got=%h expected=%h", got(), e);
    end
  endtask

  task automatic test_flush_priority();
    exp_t e;
    cyc(32'h0011_2223, 32'h4000_0020, 1'b1, 1'b1, 1'b1, 1'b0);
    e = sb.pop_front();
    checks++;
    if (got() !== e || id_inst !== 32'h13 || id_pc !== 32'h4000_0020) begin
      failures++;
      $display("FAIL flush_stall got=%h expected=%h", got(), e);
    end
  endtask

  task automatic test_illegal_bubble();
    exp_t e;
    cyc(32'h0000_007F, 32'h4000_0030, 1'b1, 1'b0, 1'b0, 1'b0);
    e = sb.pop_front();
    checks++;
    if (got() !== e || id_illegal !== 1'b1) begin
      failures++;
      $display("FAIL illegal got=%h expected=%h", got(), e);
    end
    cyc(32'h0000_007F, 32'h4000_0034, 1'b0, 1'b0, 1'b0, 1'b0);
    e = sb.pop_front();
    checks++;
    if (got() !== e || id_illegal !== 1'b0 || id_valid !== 1'b0) begin
      failures++;
      $display("FAIL bubble got=%h expected=%h", got(), e);
    end
  endtask

  task automatic test_back_to_back();
    exp_t e;
    // reset wins over a simultaneous stall and flush
    cyc(32'h0080_006F, 32'h4000_0040, 1'b1, 1'b0, 1'b0, 1'b0);
    e = sb.pop_front();
    checks++;
    if (got() !== e) begin
      failures++;
      $display("FAIL pre_rst got=%h expected=%h", got(), e);
    end
    cyc(32'h0080_006F, 32'h4000_0044, 1'b1, 1'b1, 1'b1, 1'b1);
    e = sb.pop_front();
    checks++;
    if (got() !== e) begin
      failures++;
      $display("FAIL rst_midstream got=%h expected=%h", got(), e);
    end
  endtask

  task automatic test_counter_wrap();
    exp_t e;
    force dut.inst_cnt = 32'hFFFF_FFFF;
    #1;
    release dut.inst_cnt;
    m.cnt = 32'hFFFF_FFFF;
    cyc(32'h0050_0093, 32'h4000_0050, 1'b1, 1'b0, 1'b0, 1'b0);
    e = sb.pop_front();
    checks++;
    if (got() !== e || inst_cnt !== 32'h0) begin
      failures++;
      $display("FAIL cnt_wrap got=%h expected=%h", inst_cnt, e.cnt);
    end
  endtask

  initial begin
    rst = 1'b1; if_valid = 1'b0; stall = 1'b0; flush = 1'b0;
    if_inst = 32'h0; if_pc = 32'h0;
    m = '0;
    @(posedge clk);
    #1;
    test_reset();
    test_format_decode();
    test_stall();
    test_flush_priority();
    test_illegal_bubble();
    test_back_to_back();
    test_counter_wrap();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/inst_decode_reg.md
# inst_decode_reg

Fetch-to-decode pipeline register for the RISC-V core. Captures the fetched instruction and PC, applies stall/flush control, and pre-decodes the opcode into the registered immediate-format select consumed by the immediate generator in the decode stage. Also flags unsupported opcodes and keeps a wrapping count of valid instructions entering decode.

## Interface
- RESET_PC, 32'h4000_0000, PC value held by the stage out of reset
- NOP_INST, 32'h0000_0013, bubble instruction (addi x0,x0,0)
- clk  in  1  core clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- if_inst  in  32  instruction word from IMEM/BIOS (sync-read, aligned with if_pc)
- if_pc  in  32  PC of if_inst
- if_valid  in  1  if_inst/if_pc carry a real instruction
- stall  in  1  hold all stage registers
- flush  in  1  replace the captured instruction with a bubble
- id_inst  out  32  registered instruction
- id_pc  out  32  registered PC
- id_valid  out  1  id_inst is a real (non-bubble) instruction
- imm_sel  out  3  registered immediate format: 0 I, 1 S, 2 B, 3 U, 4 J, 5 CSR-imm
- id_illegal  out  1  registered; id_valid instruction has an unsupported opcode
- id_rs1, id_rs2, id_rd  out  5 each  combinational slices id_inst[19:15], [24:20], [11:7]
- inst_cnt  out  32  count of valid instructions loaded into the stage

## Operation
- Priority per edge: rst > flush > stall > load.
- rst: id_inst=NOP_INST, id_pc=RESET_PC, id_valid=0, imm_sel=0, id_illegal=0, inst_cnt=0.
- flush (overrides stall): id_inst=NOP_INST, id_pc=if_pc, id_valid=0, imm_sel=0, id_illegal=0; inst_cnt unchanged.
- stall without flush: every register, including inst_cnt, holds its value.
- load with if_valid=0: same as flush (bubble).
- load with if_valid=1: id_inst=if_inst, id_pc=if_pc, id_valid=1, imm_sel/id_illegal from the decode below, inst_cnt=inst_cnt+1 (mod 2^32, FFFF_FFFF wraps to 0).
- imm_sel decode on if_inst[6:0]:
  - 0010011 OP-IMM, 0000011 LOAD, 1100111 JALR, 0110011 OP (don't-care, fixed 0) -> 0
  - 0100011 STORE -> 1; 1100011 BRANCH -> 2
  - 0110111 LUI, 0010111 AUIPC -> 3; 1101111 JAL -> 4
  - 1110011 SYSTEM: funct3[2]=1 (csrrwi/csrrsi/csrrci) -> 5, else -> 0
  - any other opcode -> 0 with id_illegal=1
- id_illegal is only ever 1 while id_valid=1.
- No internal state beyond the listed registers; no FSM beyond the load/hold/bubble selection.

## Timing
- Latency: one cycle, if_* sampled at edge N and visible on id_* after edge N.
- id_rs1/id_rs2/id_rd track id_inst combinationally, with zero added latency.
- stall asserted for k cycles holds outputs for exactly k edges, and the next un-stalled edge loads the current if_*.
- flush and stall in the same cycle produce a bubble, never a hold.
- rst asserted mid-stream discards the held instruction at that edge, regardless of stall/flush.
- inst_cnt updates on the same edge as the load that it counts.

## Test plan
- Reset: rst=1 for 2 cycles with if_valid=1, if_inst=0x00500093 -> id_inst=0x00000013, id_pc=0x40000000, id_valid=0, imm_sel=0, inst_cnt=0.
- Format decode: load 0x00500093, 0x00112223, 0xFE0098E3, 0x123450B7, 0x0080006F, 0x3402D073 on consecutive cycles -> imm_sel 0,1,2,3,4,5 one cycle after each, id_valid=1, inst_cnt 1..6.
- Stall: load 0x00112223 @pc 0x40000010, then stall=1 for 3 cycles while if_inst changes -> id_inst/id_pc/imm_sel=1/inst_cnt held 3 cycles, next instruction appears on the 4th edge.
- Flush priority: stall=1 and flush=1 together with if_pc=0x40000020 -> id_inst=0x00000013, id_valid=0, id_pc=0x40000020, inst_cnt unchanged.
- Illegal/bubble: load 0x0000007F -> id_illegal=1, imm_sel=0; then if_valid=0 -> id_valid=0, id_illegal=0, inst_cnt not incremented.
- Counter wrap: force inst_cnt to 0xFFFFFFFF, load one valid instruction -> inst_cnt=0x00000000.
